// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational W-bit ALU between NUM_REQ requesters,
// one operation at a time, with round-robin arbitration.
//
// Flow per operation:
//   IDLE : pick the first valid requester at or after the round-robin
//          pointer; pulse its req_ready. At the edge, capture operands,
//          function code and grant index, then advance the pointer.
//   EXEC : captured operands drive the ALU ports for one cycle. At the edge,
//          capture the ALU result and its flags.
//   RESP : raise rsp_valid for the granted requester. Hold result and flags
//          until that requester asserts rsp_ready.
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous reset, active-low
//   req_valid     [NUM_REQ]      request i presents an operation
//   req_ready     [NUM_REQ]      one-hot accept pulse (IDLE only)
//   req_a/req_b   [NUM_REQ*W]    operands; requester i uses slice [i*W +: W]
//   req_function  [NUM_REQ*3]    function code per requester
//   rsp_valid     [NUM_REQ]      one-hot: result pending for requester i
//   rsp_ready     [NUM_REQ]      requester i consumes its result
//   rsp_result    [W]            captured ALU result (shared bus)
//   rsp_zero                     captured result was zero
//   rsp_illegal                  captured function code was 5..7
//   alu_a/alu_b   [W]            operands to the ALU (registered)
//   alu_function  [3]            function code to the ALU (registered)
//   alu_result    [W]            combinational result from the ALU
//   busy                         controller is not in IDLE
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int W       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    input  logic [NUM_REQ*3-1:0] req_function,
    output logic [NUM_REQ-1:0]   rsp_valid,
    input  logic [NUM_REQ-1:0]   rsp_ready,
    output logic [W-1:0]         rsp_result,
    output logic                 rsp_zero,
    output logic                 rsp_illegal,
    output logic [W-1:0]         alu_a,
    output logic [W-1:0]         alu_b,
    output logic [2:0]           alu_function,
    input  logic [W-1:0]         alu_result,
    output logic                 busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Highest legal function code; anything above is flagged illegal but
    // still issued to the ALU unchanged.
    localparam logic [2:0] FN_MAX = 3'd4;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------

    // Pointer increment with wrap at NUM_REQ (NUM_REQ need not be a power of 2).
    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] g);
        if (g == IW'(NUM_REQ - 1)) begin
            return '0;
        end
        return g + 1'b1;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Round-robin pick: first asserted valid at or after ptr, scanning upward
    // with wrap. Returns {found, index}.
    function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [IW-1:0]      ptr);
        logic          found;
        logic [IW-1:0] idx;
        int            pos;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (!found && valid[pos[IW-1:0]]) begin
                found = 1'b1;
                idx   = pos[IW-1:0];
            end
        end
        return {found, idx};
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]    r_state;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_gnt;

    logic [W-1:0]  r_a_p0;
    logic [W-1:0]  r_b_p0;
    logic [2:0]    r_fn_p0;

    logic [W-1:0]  r_result_p1;
    logic          r_zero_p1;
    logic          r_illegal_p1;

    logic [IW:0]   w_pick;
    logic          w_found;
    logic [IW-1:0] w_gnt;
    logic          w_in_idle;
    logic          w_in_resp;

    assign w_pick    = rr_pick(req_valid, r_ptr);
    assign w_found   = w_pick[IW];
    assign w_gnt     = w_pick[IW-1:0];
    assign w_in_idle = (r_state == S_IDLE);
    assign w_in_resp = (r_state == S_RESP);

    // -----------------------------------------------------------------------
    // Accept stage (IDLE -> EXEC): operands captured into _p0
    // Capture stage (EXEC -> RESP): ALU result captured into _p1
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Data registers are cleared too: every output, alu_* included,
            // reads zero after reset.
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_gnt        <= '0;
            r_a_p0       <= '0;
            r_b_p0       <= '0;
            r_fn_p0      <= '0;
            r_result_p1  <= '0;
            r_zero_p1    <= 1'b0;
            r_illegal_p1 <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= w_gnt;
                        r_a_p0  <= req_a[int'(w_gnt)*W +: W];
                        r_b_p0  <= req_b[int'(w_gnt)*W +: W];
                        r_fn_p0 <= req_function[int'(w_gnt)*3 +: 3];
                        r_ptr   <= next_ptr(w_gnt);
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_result_p1  <= alu_result;
                    r_zero_p1    <= (alu_result == '0);
                    r_illegal_p1 <= (r_fn_p0 > FN_MAX);
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    // Only the granted requester's rsp_ready can release RESP.
                    if (rsp_ready[r_gnt]) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // req_ready is only ever raised in IDLE and rsp_valid only in RESP, so
    // the two can never be nonzero in the same cycle.
    assign req_ready    = (w_in_idle && w_found) ? onehot(w_gnt) : '0;
    assign rsp_valid    = w_in_resp ? onehot(r_gnt) : '0;

    // The ALU ports come straight from the accept-stage registers. They only
    // change on an accept edge, so they hold their last value outside EXEC.
    assign alu_a        = r_a_p0;
    assign alu_b        = r_b_p0;
    assign alu_function = r_fn_p0;

    assign rsp_result   = r_result_p1;
    assign rsp_zero     = r_zero_p1;
    assign rsp_illegal  = r_illegal_p1;

    assign busy         = !w_in_idle;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam int N = 2;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N*3-1:0] req_function;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [W-1:0]   rsp_result;
    logic           rsp_zero;
    logic           rsp_illegal;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [2:0]     alu_function;
    logic [W-1:0]   alu_result;
    logic           busy;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(N), .W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_function (req_function),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_illegal  (rsp_illegal),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_function (alu_function),
        .alu_result   (alu_result),
        .busy         (busy)
    );

    // External combinational ALU seen by the arbiter.
    always_comb begin
        alu_result = '0;
        case (alu_function)
            3'd0:    alu_result = alu_a + alu_b;
            3'd1:    alu_result = alu_a - alu_b;
            3'd2:    alu_result = alu_a & alu_b;
            3'd3:    alu_result = alu_a | alu_b;
            3'd4:    alu_result = alu_a ^ alu_b;
            default: alu_result = '0;
        endcase
    end

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [1:0] idx;
        logic [3:0] res;
        logic       z;
        logic       ill;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] oh(input int i);
        logic [1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic push(input int idx, input logic [3:0] res, input logic z, input logic ill);
        exp_t e;
        e.idx = 2'(idx);
        e.res = res;
        e.z   = z;
        e.ill = ill;
        sb.push_back(e);
    endtask

    // Called about 1 ns after a falling edge while the DUT should be in RESP.
    task automatic check_resp(input string tag);
        exp_t e;
        chk({tag, "_sb_pending"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_rsp_valid"}, rsp_valid, oh(int'(e.idx)));
            chk({tag, "_result"}, rsp_result, e.res);
            chk({tag, "_flags"}, {rsp_zero, rsp_illegal}, {e.z, e.ill});
        end
    endtask

    // Bounded wait for an accept pulse, then check that it went to idx.
    task automatic wait_grant(input string tag, input int idx);
        int t;
        t = 0;
        #1;
        while (req_ready == '0 && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk({tag, "_grant"}, req_ready, oh(idx));
    endtask

    // Caller is at a falling edge. Presents one op, follows it through EXEC
    // into RESP, and scrambles the request fields after the accept.
    task automatic issue(input string tag, input int idx, input logic [3:0] a,
                         input logic [3:0] b, input logic [2:0] fn,
                         input logic [3:0] res, input logic z, input logic ill);
        req_a[idx*W +: W]        = a;
        req_b[idx*W +: W]        = b;
        req_function[idx*3 +: 3] = fn;
        req_valid[idx]           = 1'b1;
        wait_grant(tag, idx);
        push(idx, res, z, ill);
        @(negedge clk);
        req_valid[idx]           = 1'b0;
        req_a[idx*W +: W]        = ~a;
        req_b[idx*W +: W]        = ~b;
        req_function[idx*3 +: 3] = fn ^ 3'd1;
        #1;
        chk({tag, "_exec_alu"}, {alu_a, alu_b, alu_function}, {a, b, fn});
        chk({tag, "_exec_state"}, {busy, rsp_valid, req_ready}, {1'b1, 2'b00, 2'b00});
        @(negedge clk);
        #1;
        check_resp(tag);
    endtask

    task automatic release_rsp(input string tag, input int idx);
        rsp_ready[idx] = 1'b1;
        @(negedge clk);
        rsp_ready = '0;
        #1;
        chk({tag, "_idle"}, {busy, rsp_valid}, 3'b000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int last;
        int exp_g;
        int ngr;

        rst_n        = 1'b0;
        req_valid    = '0;
        req_a        = '0;
        req_b        = '0;
        req_function = '0;
        rsp_ready    = '0;

        // 1. Reset release, no requests: everything stays at zero.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("t1_idle_outputs",
                {req_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal,
                 alu_a, alu_b, alu_function, busy}, 0);
        end

        // 2. Basic ADD from requester 0, two-cycle latency.
        @(negedge clk);
        issue("t2_add", 0, 4'h7, 4'h5, 3'd0, 4'hC, 1'b0, 1'b0);
        release_rsp("t2", 0);

        // 3. Wrap-around arithmetic and flags.
        @(negedge clk);
        issue("t3_sub", 1, 4'h3, 4'h5, 3'd1, 4'hE, 1'b0, 1'b0);
        release_rsp("t3_sub", 1);
        @(negedge clk);
        issue("t3_wrap", 0, 4'h9, 4'h7, 3'd0, 4'h0, 1'b1, 1'b0);
        release_rsp("t3_wrap", 0);
        @(negedge clk);
        issue("t3_illegal", 1, 4'hF, 4'hF, 3'd6, 4'h0, 1'b1, 1'b1);
        release_rsp("t3_illegal", 1);

        // 4. Both requesters streaming, rsp_ready tied high.
        @(negedge clk);
        req_a        = {4'h4, 4'h1};
        req_b        = {4'h8, 4'h2};
        req_function = {3'd3, 3'd0};
        req_valid    = 2'b11;
        rsp_ready    = 2'b11;
        last  = -3;
        exp_g = 0;
        ngr   = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            chk("t4_exclusive", 32'((req_ready != '0) && (rsp_valid != '0)), 0);
            if (req_ready != '0) begin
                chk("t4_grant_order", req_ready, oh(exp_g));
                chk("t4_spacing", cyc - last, 3);
                push(exp_g, (exp_g == 0) ? 4'h3 : 4'hC, 1'b0, 1'b0);
                last  = cyc;
                exp_g = exp_g ^ 1;
                ngr++;
            end
            if (rsp_valid != '0) begin
                check_resp("t4");
            end
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = '0;
        chk("t4_grant_count", ngr, 4);

        // 5. Backpressure on requester 0 while requester 1 waits.
        @(negedge clk);
        req_a[7:4]        = 4'h5;
        req_b[7:4]        = 4'hA;
        req_function[5:3] = 3'd3;
        req_valid[1]      = 1'b1;
        issue("t5_xor", 0, 4'h3, 4'h6, 3'd4, 4'h5, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("t5_hold_rsp", {rsp_valid, rsp_result, rsp_zero, rsp_illegal},
                {2'b01, 4'h5, 1'b0, 1'b0});
            chk("t5_hold_no_ready", req_ready, 2'b00);
        end
        release_rsp("t5_rel0", 0);
        chk("t5_next_grant", req_ready, 2'b10);
        push(1, 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("t5_exec1_alu", {alu_a, alu_b, alu_function}, {4'h5, 4'hA, 3'd3});
        @(negedge clk);
        #1;
        check_resp("t5_req1");
        release_rsp("t5_rel1", 1);

        // 6. Reset during EXEC abandons the op and clears the pointer.
        @(negedge clk);
        req_a[3:0]        = 4'hA;
        req_b[3:0]        = 4'h5;
        req_function[2:0] = 3'd4;
        req_valid[0]      = 1'b1;
        wait_grant("t6_xor", 0);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("t6_exec_alu", {alu_a, alu_b, alu_function}, {4'hA, 4'h5, 3'd4});
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("t6_reset_outputs",
            {req_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal,
             alu_a, alu_b, alu_function, busy}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("t6_no_response",
            {req_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal, busy}, 0);

        @(negedge clk);
        req_a        = {4'h2, 4'h2};
        req_b        = {4'h3, 4'h3};
        req_function = {3'd1, 3'd0};
        req_valid    = 2'b11;
        #1;
        chk("t6_tie_after_reset", req_ready, 2'b01);
        push(0, 4'h5, 1'b0, 1'b0);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        #1;
        check_resp("t6_req0");
        release_rsp("t6_rel0", 0);
        chk("t6_req1_grant", req_ready, 2'b10);
        push(1, 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        check_resp("t6_req1");
        release_rsp("t6_rel1", 1);

        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
